// File: rtl/cu_pkg.sv
// Control-unit shared definitions: FSM states, unit indices, opcode fields.
package cu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NUM_UNITS = 7;
  localparam int unsigned UNIT_W    = 3;
  localparam int unsigned OPC_W     = 5;
  localparam int unsigned CNT_W     = 64;

  // Unit indices; also the bit position in start/done
  localparam logic [UNIT_W-1:0] U_ALU    = 3'd0;
  localparam logic [UNIT_W-1:0] U_LOAD   = 3'd1;
  localparam logic [UNIT_W-1:0] U_STORE  = 3'd2;
  localparam logic [UNIT_W-1:0] U_BRANCH = 3'd3;
  localparam logic [UNIT_W-1:0] U_JUMP   = 3'd4;
  localparam logic [UNIT_W-1:0] U_UPPER  = 3'd5;
  localparam logic [UNIT_W-1:0] U_FPU    = 3'd6;

  // Major opcode values of ins[6:2]
  localparam logic [OPC_W-1:0] OPC_LOAD      = 5'd0;
  localparam logic [OPC_W-1:0] OPC_LOAD_FP   = 5'd1;
  localparam logic [OPC_W-1:0] OPC_OP_IMM    = 5'd4;
  localparam logic [OPC_W-1:0] OPC_AUIPC     = 5'd5;
  localparam logic [OPC_W-1:0] OPC_OP_IMM_32 = 5'd6;
  localparam logic [OPC_W-1:0] OPC_STORE     = 5'd8;
  localparam logic [OPC_W-1:0] OPC_STORE_FP  = 5'd9;
  localparam logic [OPC_W-1:0] OPC_OP        = 5'd12;
  localparam logic [OPC_W-1:0] OPC_LUI       = 5'd13;
  localparam logic [OPC_W-1:0] OPC_OP_32     = 5'd14;
  localparam logic [OPC_W-1:0] OPC_MADD      = 5'd16;
  localparam logic [OPC_W-1:0] OPC_MSUB      = 5'd17;
  localparam logic [OPC_W-1:0] OPC_NMSUB     = 5'd18;
  localparam logic [OPC_W-1:0] OPC_NMADD     = 5'd19;
  localparam logic [OPC_W-1:0] OPC_OP_FP     = 5'd20;
  localparam logic [OPC_W-1:0] OPC_BRANCH    = 5'd24;
  localparam logic [OPC_W-1:0] OPC_JALR      = 5'd25;
  localparam logic [OPC_W-1:0] OPC_JAL       = 5'd27;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_DISPATCH = 3'd3,
    ST_WAIT     = 3'd4,
    ST_TRAP     = 3'd5
  } state_e;

  // One-hot mask for a unit index
  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [UNIT_W-1:0] u);
    return NUM_UNITS'(1) << u;
  endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Maps an instruction word to its executing unit and flags illegal encodings.
module opcode_classifier
  import cu_pkg::*;
(
  input  logic [XLEN-1:0]   ins,
  output logic [UNIT_W-1:0] unit,
  output logic              illegal
);

  // Only the opcode field matters here
  logic unused_ins_hi;
  assign unused_ins_hi = ^ins[XLEN-1:7];

  // Opcode-to-unit lookup; anything unmapped or non-32-bit is illegal
  always_comb begin
    unit    = U_ALU;
    illegal = 1'b0;
    case (ins[6:2])
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32:         unit = U_ALU;
      OPC_LOAD, OPC_LOAD_FP:                                unit = U_LOAD;
      OPC_STORE, OPC_STORE_FP:                              unit = U_STORE;
      OPC_BRANCH:                                           unit = U_BRANCH;
      OPC_JALR, OPC_JAL:                                    unit = U_JUMP;
      OPC_AUIPC, OPC_LUI:                                   unit = U_UPPER;
      OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD, OPC_OP_FP:  unit = U_FPU;
      default:                                              illegal = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) illegal = 1'b1;
  end

endmodule

// File: rtl/fsm_dispatcher.sv
// Top-level sequencer: fetch, decode, dispatch to one unit, wait for completion.
module fsm_dispatcher
  import cu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 mem_req,
  input  logic                 mem_ready,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [XLEN-1:0]      ins,
  output logic [XLEN-1:0]      code,
  output logic [NUM_UNITS-1:0] start,
  input  logic [NUM_UNITS-1:0] done,
  output logic [UNIT_W-1:0]    owner,
  output logic                 owner_valid,
  output logic [CNT_W-1:0]     instret,
  output logic                 err_illegal,
  output logic                 err_timeout,
  output logic                 err_spurious
);

  localparam int unsigned    WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [WD_W-1:0]        wdog_q, wdog_d;
  logic                   mem_req_d;
  logic [XLEN-1:0]        ins_d, code_d;
  logic [NUM_UNITS-1:0]   start_d;
  logic [UNIT_W-1:0]      owner_d;
  logic                   owner_valid_d;
  logic [CNT_W-1:0]       instret_d;
  logic                   err_illegal_d, err_timeout_d, err_spurious_d;
  logic [NUM_UNITS-1:0]   owner_mask;
  logic                   done_own, done_stray;

  logic [UNIT_W-1:0]      cls_unit;
  logic                   cls_illegal;

  opcode_classifier u_classifier (
    .ins     (ins),
    .unit    (cls_unit),
    .illegal (cls_illegal)
  );

  // Next-state and next-output logic; outputs are registered one cycle ahead
  always_comb begin
    state_d        = state_q;
    wdog_d         = wdog_q;
    ins_d          = ins;
    code_d         = code;
    start_d        = '0;
    owner_d        = owner;
    owner_valid_d  = owner_valid;
    instret_d      = instret;
    err_illegal_d  = err_illegal;
    err_timeout_d  = err_timeout;
    err_spurious_d = err_spurious;
    owner_mask     = unit_onehot(owner);
    done_own       = |(done & owner_mask);
    done_stray     = (state_q == ST_WAIT) ? |(done & ~owner_mask) : |done;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ready) begin
          ins_d   = mem_rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        code_d = XLEN'(1) << ins[6:2];
        if (cls_illegal) begin
          err_illegal_d = 1'b1;
          state_d       = ST_TRAP;
        end else begin
          start_d       = unit_onehot(cls_unit);
          owner_d       = cls_unit;
          owner_valid_d = 1'b1;
          state_d       = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wdog_q != '1) wdog_d = wdog_q + WD_W'(1);
        // Completion takes priority over a watchdog expiring the same cycle
        if (done_own) begin
          instret_d     = instret + CNT_W'(1);
          owner_valid_d = 1'b0;
          state_d       = run ? ST_FETCH : ST_IDLE;
        end else if (wdog_q == WD_LIMIT) begin
          err_timeout_d = 1'b1;
          owner_valid_d = 1'b0;
          state_d       = ST_TRAP;
        end
      end
      ST_TRAP: begin
        owner_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (done_stray) err_spurious_d = 1'b1;
    mem_req_d = (state_d == ST_FETCH);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      wdog_q       <= '0;
      mem_req      <= 1'b0;
      ins          <= '0;
      code         <= '0;
      start        <= '0;
      owner        <= '0;
      owner_valid  <= 1'b0;
      instret      <= '0;
      err_illegal  <= 1'b0;
      err_timeout  <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      state_q      <= state_d;
      wdog_q       <= wdog_d;
      mem_req      <= mem_req_d;
      ins          <= ins_d;
      code         <= code_d;
      start        <= start_d;
      owner        <= owner_d;
      owner_valid  <= owner_valid_d;
      instret      <= instret_d;
      err_illegal  <= err_illegal_d;
      err_timeout  <= err_timeout_d;
      err_spurious <= err_spurious_d;
    end
  end

endmodule

// File: tb/tb_fsm_dispatcher.sv
// Directed bench for fsm_dispatcher (TIMEOUT = 8).
module tb_fsm_dispatcher;

  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] LW  = 32'h0000A103;
  localparam logic [31:0] SW  = 32'h0020A023;
  localparam logic [31:0] BEQ = 32'h00208063;
  localparam logic [31:0] LUI = 32'h12345037;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        mem_req;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ins;
  logic [31:0] code;
  logic [6:0]  start;
  logic [6:0]  done = '0;
  logic [2:0]  owner;
  logic        owner_valid;
  logic [63:0] instret;
  logic        err_illegal, err_timeout, err_spurious;

  int errors = 0;
  int checks = 0;

  fsm_dispatcher #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .ins          (ins),
    .code         (code),
    .start        (start),
    .done         (done),
    .owner        (owner),
    .owner_valid  (owner_valid),
    .instret      (instret),
    .err_illegal  (err_illegal),
    .err_timeout  (err_timeout),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; run = 1'b0; mem_ready = 1'b0; mem_rdata = '0; done = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // From IDLE: fetch one word, leave the bench in the WAIT entry cycle
  task automatic issue(input logic [31:0] w);
    run = 1'b1; tick();
    mem_ready = 1'b1; mem_rdata = w; tick();
    mem_ready = 1'b0; tick();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({mem_req, start, owner, owner_valid, err_illegal, err_timeout, err_spurious} !== 15'd0) begin
      errors++; $display("FAIL reset_ctrl: got %h expected 0",
        {mem_req, start, owner, owner_valid, err_illegal, err_timeout, err_spurious});
    end
    checks++;
    if ({ins, code, instret} !== 128'd0) begin
      errors++; $display("FAIL reset_data: ins=%h code=%h instret=%h expected all 0", ins, code, instret);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_rtype();
    apply_reset();
    run = 1'b1; tick();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rt_fetch_req: got %b expected 1", mem_req); end
    mem_ready = 1'b1; mem_rdata = ADD; tick();
    mem_ready = 1'b0; mem_rdata = '0;
    checks++;
    if (ins !== ADD) begin errors++; $display("FAIL rt_ins: got %h expected %h", ins, ADD); end
    checks++;
    if (start !== 7'd0) begin errors++; $display("FAIL rt_decode_start: got %b expected 0", start); end
    tick();
    checks++;
    if (code !== 32'h00001000) begin errors++; $display("FAIL rt_code: got %h expected 00001000", code); end
    checks++;
    if (start !== 7'b0000001) begin errors++; $display("FAIL rt_start: got %b expected 0000001", start); end
    checks++;
    if ({owner_valid, owner} !== 4'b1_000) begin
      errors++; $display("FAIL rt_owner: valid=%b owner=%0d expected 1/0", owner_valid, owner);
    end
    tick();
    checks++;
    if (start !== 7'd0) begin errors++; $display("FAIL rt_start_pulse: got %b expected 0", start); end
    tick(); tick();
    done = 7'b0000001; tick(); done = '0;
    checks++;
    if (instret !== 64'd1) begin errors++; $display("FAIL rt_instret: got %0d expected 1", instret); end
    checks++;
    if ({mem_req, owner_valid} !== 2'b10) begin
      errors++; $display("FAIL rt_refetch: req=%b valid=%b expected 1/0", mem_req, owner_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words     [3];
    logic [6:0]  exp_start [3];
    logic [31:0] exp_code  [3];
    words[0] = LW;  exp_start[0] = 7'b0000010; exp_code[0] = 32'h00000001;
    words[1] = SW;  exp_start[1] = 7'b0000100; exp_code[1] = 32'h00000100;
    words[2] = BEQ; exp_start[2] = 7'b0001000; exp_code[2] = 32'h01000000;
    apply_reset();
    run = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL b2b_req[%0d]: got %b expected 1", i, mem_req); end
      mem_ready = 1'b1; mem_rdata = words[i]; tick();
      mem_ready = 1'b0; tick();
      checks++;
      if (start !== exp_start[i]) begin
        errors++; $display("FAIL b2b_start[%0d]: got %b expected %b", i, start, exp_start[i]);
      end
      checks++;
      if (code !== exp_code[i]) begin
        errors++; $display("FAIL b2b_code[%0d]: got %h expected %h", i, code, exp_code[i]);
      end
      tick();
      checks++;
      if (start !== 7'd0) begin errors++; $display("FAIL b2b_pulse[%0d]: got %b expected 0", i, start); end
      done = exp_start[i]; tick(); done = '0;
    end
    checks++;
    if (instret !== 64'd3) begin errors++; $display("FAIL b2b_instret: got %0d expected 3", instret); end
    checks++;
    if ({err_illegal, err_timeout, err_spurious} !== 3'b000) begin
      errors++; $display("FAIL b2b_errs: got %b expected 000", {err_illegal, err_timeout, err_spurious});
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    run = 1'b1; tick();
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF; tick();
    mem_ready = 1'b0; tick();
    checks++;
    if (err_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b expected 1", err_illegal); end
    checks++;
    if ({start, owner_valid} !== 8'd0) begin
      errors++; $display("FAIL ill_no_start: start=%b valid=%b expected 0/0", start, owner_valid);
    end
    for (int k = 0; k < 6; k++) begin
      mem_ready = k[0];
      checks++;
      if ({mem_req, start} !== 8'd0) begin
        errors++; $display("FAIL ill_trap[%0d]: req=%b start=%b expected 0/0", k, mem_req, start);
      end
      tick();
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_watchdog();
    apply_reset();
    issue(ADD);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_early[%0d]: got %b expected 0", k, err_timeout); end
      tick();
    end
    checks++;
    if (err_timeout !== 1'b1) begin errors++; $display("FAIL wd_trap: got %b expected 1", err_timeout); end
    checks++;
    if ({owner_valid, mem_req} !== 2'b00) begin
      errors++; $display("FAIL wd_trap_outs: valid=%b req=%b expected 0/0", owner_valid, mem_req);
    end
    checks++;
    if (instret !== 64'd0) begin errors++; $display("FAIL wd_instret: got %0d expected 0", instret); end
    // Completion on the limit cycle must retire instead of trapping
    apply_reset();
    issue(ADD);
    for (int k = 0; k < 7; k++) tick();
    done = 7'b0000001; tick(); done = '0;
    checks++;
    if (err_timeout !== 1'b0) begin errors++; $display("FAIL wd_race_flag: got %b expected 0", err_timeout); end
    checks++;
    if ({instret, mem_req} !== {64'd1, 1'b1}) begin
      errors++; $display("FAIL wd_race_retire: instret=%0d req=%b expected 1/1", instret, mem_req);
    end
  endtask

  task automatic test_spurious_backpressure();
    apply_reset();
    run = 1'b1; tick();
    mem_ready = 1'b1; mem_rdata = ADD; tick();
    mem_ready = 1'b0; tick();
    mem_ready = 1'b1; mem_rdata = 32'h12345678; tick();
    mem_ready = 1'b0;
    checks++;
    if (ins !== ADD) begin errors++; $display("FAIL sp_ready_no_req: got %h expected %h", ins, ADD); end
    done = 7'b0010000; tick(); done = '0;
    checks++;
    if (err_spurious !== 1'b1) begin errors++; $display("FAIL sp_flag: got %b expected 1", err_spurious); end
    checks++;
    if ({owner_valid, mem_req, err_timeout} !== 3'b100) begin
      errors++; $display("FAIL sp_still_wait: valid=%b req=%b to=%b expected 1/0/0", owner_valid, mem_req, err_timeout);
    end
    checks++;
    if (instret !== 64'd0) begin errors++; $display("FAIL sp_instret: got %0d expected 0", instret); end
    done = 7'b0000001; tick(); done = '0;
    checks++;
    if (instret !== 64'd1) begin errors++; $display("FAIL sp_retire: got %0d expected 1", instret); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({mem_req, ins} !== {1'b1, ADD}) begin
        errors++; $display("FAIL bp_hold[%0d]: req=%b ins=%h expected 1/%h", k, mem_req, ins, ADD);
      end
      mem_rdata = 32'hDEADBEEF; tick();
    end
    mem_ready = 1'b1; mem_rdata = LUI; tick();
    mem_ready = 1'b0;
    checks++;
    if (ins !== LUI) begin errors++; $display("FAIL bp_latch: got %h expected %h", ins, LUI); end
    tick();
    checks++;
    if ({start, code} !== {7'b0100000, 32'h00002000}) begin
      errors++; $display("FAIL bp_upper: start=%b code=%h expected 0100000/00002000", start, code);
    end
  endtask

  task automatic test_run_drop();
    apply_reset();
    issue(ADD);
    run = 1'b0; tick();
    done = 7'b0000001; tick(); done = '0;
    checks++;
    if ({instret, owner_valid, mem_req} !== {64'd1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rd_idle: instret=%0d valid=%b req=%b expected 1/0/0", instret, owner_valid, mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_stay_idle: got %b expected 0", mem_req); end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    issue(ADD);
    done = 7'b0000001; tick(); done = '0;
    mem_ready = 1'b1; mem_rdata = LUI; tick();
    mem_ready = 1'b0; tick();
    tick(); tick();
    checks++;
    if ({owner_valid, owner, instret} !== {1'b1, 3'd5, 64'd1}) begin
      errors++; $display("FAIL rm_pre: valid=%b owner=%0d instret=%0d expected 1/5/1", owner_valid, owner, instret);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_req, start, owner, owner_valid} !== 12'd0) begin
      errors++; $display("FAIL rm_async_ctrl: req=%b start=%b owner=%0d valid=%b expected 0", mem_req, start, owner, owner_valid);
    end
    checks++;
    if ({ins, code, instret} !== 128'd0) begin
      errors++; $display("FAIL rm_async_data: ins=%h code=%h instret=%0d expected 0", ins, code, instret);
    end
    tick();
    rst = 1'b0; run = 1'b1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_release: got %b expected 0", mem_req); end
    tick();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_first_req: got %b expected 1", mem_req); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_back_to_back();
    test_illegal();
    test_watchdog();
    test_spurious_backpressure();
    test_run_drop();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
